// File: rtl/spi_host_rx_byte_merge.sv
// spi_host_rx_byte_merge
// Packs the receive byte stream from the SPI host shift register into 32-bit
// words with byte enables for the RX FIFO. A word closes after four bytes or
// on a byte flagged last-in-segment. In a partial word the unused lanes are
// zero and their enables are clear.
// ByteOrder = 0 puts the first byte in [7:0]. ByteOrder = 1 puts it in [31:24].
// Optional feature: define SPI_HOST_RX_MERGE_STATS_EN to add rx_byte_cnt_o,
// a saturating 16-bit count of accepted bytes.
module spi_host_rx_byte_merge #(
  parameter int unsigned ByteOrder = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  input  logic        byte_last_i,
  output logic        byte_ready_o,
  output logic [31:0] word_o,
  output logic [3:0]  word_be_o,
  output logic        word_valid_o,
  input  logic        word_ready_i,
`ifdef SPI_HOST_RX_MERGE_STATS_EN
  output logic [15:0] rx_byte_cnt_o,
`endif
  input  logic        sw_rst_i
);

  typedef enum logic {
    EMPTY = 1'b0,
    ACCUM = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] acc_data_q, acc_data_d;
  logic [3:0]  acc_be_q, acc_be_d;
  logic [31:0] word_q, word_d;
  logic [3:0]  be_q, be_d;
  logic        valid_q, valid_d;

  logic        byte_accept;
  logic        byte_close;
  logic [1:0]  lane;
  logic [31:0] merged_data;
  logic [3:0]  merged_be;

  // Accept a byte unless the output register is full and not draining.
  // The same rule applies to non-closing bytes, so ordering stays trivial.
  assign byte_ready_o = !sw_rst_i && (!valid_q || word_ready_i);
  assign byte_accept  = byte_valid_i && byte_ready_o;
  assign byte_close   = (cnt_q == 2'd3) || byte_last_i;
  assign lane         = (ByteOrder == 1) ? (2'd3 - cnt_q) : cnt_q;
  assign merged_data  = acc_data_q | (32'(byte_i) << {lane, 3'b000});
  assign merged_be    = acc_be_q | (4'b0001 << lane);

  assign word_o       = word_q;
  assign word_be_o    = be_q;
  assign word_valid_o = valid_q;

  // Compute the next state, the lane count, the accumulator and the output register.
  always_comb begin
    // NOTE: every signal gets a default before any branch.
    // That way no path leaves a signal unassigned, and no latch is inferred.
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_data_d = acc_data_q;
    acc_be_d   = acc_be_q;
    word_d     = word_q;
    be_d       = be_q;
    valid_d    = valid_q;

    if (word_ready_i) begin
      valid_d = 1'b0;
    end

    if (byte_accept) begin
      if (byte_close) begin
        word_d     = merged_data;
        be_d       = merged_be;
        valid_d    = 1'b1;
        acc_data_d = '0;
        acc_be_d   = '0;
        cnt_d      = 2'd0;
      end else begin
        acc_data_d = merged_data;
        acc_be_d   = merged_be;
        cnt_d      = cnt_q + 2'd1;
      end
    end

    case (state_q)
      EMPTY:   if (byte_accept && !byte_close) state_d = ACCUM;
      ACCUM:   if (byte_accept && byte_close)  state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Register the state. Either reset input drops any partial word and any pending word.
  always_ff @(posedge clk_i) begin
    // NOTE: state uses non-blocking assignments.
    // Every flop then samples the pre-edge values.
    if (rst_i || sw_rst_i) begin
      state_q    <= EMPTY;
      cnt_q      <= 2'd0;
      acc_data_q <= '0;
      acc_be_q   <= '0;
      word_q     <= '0;
      be_q       <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_data_q <= acc_data_d;
      acc_be_q   <= acc_be_d;
      word_q     <= word_d;
      be_q       <= be_d;
      valid_q    <= valid_d;
    end
  end

`ifdef SPI_HOST_RX_MERGE_STATS_EN
  logic [15:0] byte_cnt_q;

  // Count accepted bytes, saturating at all-ones.
  always_ff @(posedge clk_i) begin
    if (rst_i || sw_rst_i) begin
      byte_cnt_q <= '0;
    end else if (byte_accept && (byte_cnt_q != 16'hFFFF)) begin
      byte_cnt_q <= byte_cnt_q + 16'd1;
    end
  end

  assign rx_byte_cnt_o = byte_cnt_q;
`endif

endmodule

// File: tb/tb_spi_host_rx_byte_merge.sv
// Testbench for spi_host_rx_byte_merge. Two instances share all inputs:
// u_dut0 has ByteOrder=0 and u_dut1 has ByteOrder=1. The reference model
// keeps the bytes of the open word in a queue. When a word closes, the model
// computes the expected word for each byte order and pushes it to a
// scoreboard queue. A monitor pops an entry on every word handshake.
// Covers the SPI_HOST_RX_MERGE_STATS_EN counter when that macro is defined.
module tb_spi_host_rx_byte_merge;

  logic        clk = 1'b0;
  logic        rst;
  logic        sw_rst;
  logic [7:0]  byte_d;
  logic        bv;
  logic        bl;
  logic        wr;

  logic        rdy0, rdy1;
  logic [31:0] word0, word1;
  logic [3:0]  be0, be1;
  logic        wv0, wv1;
`ifdef SPI_HOST_RX_MERGE_STATS_EN
  logic [15:0] cnt0, cnt1;
`endif

  int checks = 0;
  int errors = 0;

  logic        exp_full = 1'b0;
  int          exp_cnt  = 0;
  logic [7:0]  cur[$];
  logic [35:0] q0[$];
  logic [35:0] q1[$];

  always #5 clk = ~clk;

  spi_host_rx_byte_merge #(.ByteOrder(0)) u_dut0 (
    .clk_i        (clk),
    .rst_i        (rst),
    .byte_i       (byte_d),
    .byte_valid_i (bv),
    .byte_last_i  (bl),
    .byte_ready_o (rdy0),
    .word_o       (word0),
    .word_be_o    (be0),
    .word_valid_o (wv0),
    .word_ready_i (wr),
`ifdef SPI_HOST_RX_MERGE_STATS_EN
    .rx_byte_cnt_o(cnt0),
`endif
    .sw_rst_i     (sw_rst)
  );

  spi_host_rx_byte_merge #(.ByteOrder(1)) u_dut1 (
    .clk_i        (clk),
    .rst_i        (rst),
    .byte_i       (byte_d),
    .byte_valid_i (bv),
    .byte_last_i  (bl),
    .byte_ready_o (rdy1),
    .word_o       (word1),
    .word_be_o    (be1),
    .word_valid_o (wv1),
    .word_ready_i (wr),
`ifdef SPI_HOST_RX_MERGE_STATS_EN
    .rx_byte_cnt_o(cnt1),
`endif
    .sw_rst_i     (sw_rst)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Expected {be, data} for the bytes in cur. Byte i goes to lane i,
  // or to lane 3-i when order is 1.
  function automatic logic [35:0] build_word(input int order);
    logic [31:0] data;
    logic [3:0]  be;
    int          lane;
    data = '0;
    be   = '0;
    for (int i = 0; i < cur.size(); i++) begin
      lane     = (order == 1) ? 3 - i : i;
      data     = data | (32'(cur[i]) << (8 * lane));
      be[lane] = 1'b1;
    end
    return {be, data};
  endfunction

  // Drive one cycle of inputs and check the flags against the model.
  // Then advance the model by the effect of the coming clock edge.
  task automatic drive_cycle(input logic v, input logic [7:0] b, input logic l,
                             input logic w, input logic s, input logic r,
                             output logic acc);
    logic exp_ready;
    logic closed;
    @(negedge clk);
    bv = v; byte_d = b; bl = l; wr = w; sw_rst = s; rst = r;
    #1;
    exp_ready = !s && (!exp_full || w);
    check("word_valid0", 64'(wv0), 64'(exp_full));
    check("word_valid1", 64'(wv1), 64'(exp_full));
    check("byte_ready0", 64'(rdy0), 64'(exp_ready));
    check("byte_ready1", 64'(rdy1), 64'(exp_ready));
    acc    = v && exp_ready && !r;
    closed = 1'b0;
    if (r || s) begin
      cur.delete();
      exp_full = 1'b0;
      exp_cnt  = 0;
    end else begin
      if (acc) begin
        cur.push_back(b);
        if (exp_cnt < 65535) exp_cnt++;
        if (cur.size() == 4 || l) begin
          q0.push_back(build_word(0));
          q1.push_back(build_word(1));
          cur.delete();
          closed = 1'b1;
        end
      end
      exp_full = closed ? 1'b1 : (w ? 1'b0 : exp_full);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic l, input logic w);
    logic acc;
    acc = 1'b0;
    for (int n = 0; n < 20 && !acc; n++) begin
      drive_cycle(1'b1, b, l, w, 1'b0, 1'b0, acc);
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=not_accepted expected=accepted byte=%0h", b);
    end
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, acc);
  endtask

  // Monitor: pop and compare one expected word on every word handshake.
  initial begin
    logic [35:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (wv0 === 1'b1 && wr === 1'b1) begin
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL word0_unexpected actual=%0h expected=none", {be0, word0});
        end else begin
          e = q0.pop_front();
          check("word0", 64'({be0, word0}), 64'(e));
        end
      end
      if (wv1 === 1'b1 && wr === 1'b1) begin
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL word1_unexpected actual=%0h expected=none", {be1, word1});
        end else begin
          e = q1.pop_front();
          check("word1", 64'({be1, word1}), 64'(e));
        end
      end
    end
  end

  initial begin
    logic acc;
    logic v, l, w, s;
    logic [7:0] b;

    rst = 1'b1; sw_rst = 1'b0; bv = 1'b0; bl = 1'b0; byte_d = 8'h00; wr = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_word_valid0", 64'(wv0), 64'd0);
    check("rst_word0", 64'(word0), 64'd0);
    check("rst_be0", 64'(be0), 64'd0);
    check("rst_word_valid1", 64'(wv1), 64'd0);
    check("rst_word1", 64'(word1), 64'd0);
    check("rst_be1", 64'(be1), 64'd0);
    check("rst_byte_ready0", 64'(rdy0), 64'd1);
`ifdef SPI_HOST_RX_MERGE_STATS_EN
    check("rst_cnt0", 64'(cnt0), 64'd0);
`endif
    idle(1);

    // Four bytes back to back. Valid must be seen the cycle after the 4th byte.
    send_byte(8'h11, 1'b0, 1'b1);
    send_byte(8'h22, 1'b0, 1'b1);
    send_byte(8'h33, 1'b0, 1'b1);
    send_byte(8'h44, 1'b0, 1'b1);
    idle(2);

    // Two-byte word closed by last.
    send_byte(8'hAA, 1'b0, 1'b1);
    send_byte(8'hBB, 1'b1, 1'b1);
    idle(2);

    // Back-pressure: output full, further bytes stall, then two words in order.
    send_byte(8'h11, 1'b0, 1'b0);
    send_byte(8'h22, 1'b0, 1'b0);
    send_byte(8'h33, 1'b0, 1'b0);
    send_byte(8'h44, 1'b0, 1'b0);
    repeat (3) drive_cycle(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    send_byte(8'h55, 1'b0, 1'b1);
    send_byte(8'h66, 1'b0, 1'b1);
    send_byte(8'h77, 1'b0, 1'b1);
    send_byte(8'h88, 1'b0, 1'b1);
    idle(2);

    // Single-byte word.
    send_byte(8'h5A, 1'b1, 1'b1);
    idle(2);

    // Software reset mid-word discards the partial word.
    send_byte(8'hA1, 1'b0, 1'b1);
    send_byte(8'hA2, 1'b0, 1'b1);
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, acc);
    send_byte(8'h01, 1'b0, 1'b1);
    send_byte(8'h02, 1'b0, 1'b1);
    send_byte(8'h03, 1'b0, 1'b1);
    send_byte(8'h04, 1'b0, 1'b1);
    idle(2);

    // Hardware reset mid-word.
    send_byte(8'hC1, 1'b0, 1'b1);
    send_byte(8'hC2, 1'b0, 1'b1);
    send_byte(8'hC3, 1'b0, 1'b1);
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, acc);
    send_byte(8'hD1, 1'b0, 1'b1);
    send_byte(8'hD2, 1'b1, 1'b1);
    idle(2);

`ifdef SPI_HOST_RX_MERGE_STATS_EN
    check("stats_cnt0", 64'(cnt0), 64'(exp_cnt));
    check("stats_cnt1", 64'(cnt1), 64'(exp_cnt));
`endif

    // Randomized traffic with back-pressure and occasional software reset.
    repeat (2000) begin
      v = ($urandom_range(0, 3) != 0);
      b = 8'($urandom);
      l = ($urandom_range(0, 3) == 0);
      w = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 99) == 0);
      if (s) w = 1'b1;
      drive_cycle(v, b, l, w, s, 1'b0, acc);
    end
    idle(3);

`ifdef SPI_HOST_RX_MERGE_STATS_EN
    check("stats_cnt0_end", 64'(cnt0), 64'(exp_cnt));
`endif
    check("q0_drained", 64'(q0.size()), 64'd0);
    check("q1_drained", 64'(q1.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
